// File: rtl/mux_scan_serializer_pkg.sv
// Shared types and defaults for the mux scan serializer and its selector.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } scan_state_t;

  localparam int SCAN_DEFAULT_N = 16;

endpackage

// File: rtl/mux_scan_serializer_if.sv
// Load handshake, serial port and selector-side status of the scan serializer.
interface mux_scan_serializer_if #(
  parameter int N = 16
);
  localparam int SEL_W = $clog2(N);

  logic             load_valid;
  logic             load_ready;
  logic [N-1:0]     load_data;
  logic             ser_valid;
  logic             ser_ready;
  logic             ser_bit;
  logic             ser_last;
  logic [SEL_W-1:0] sel;
  logic             busy;

  // master is the serializer; slave is the upstream/downstream environment
  modport master (
    input  load_valid, load_data, ser_ready,
    output load_ready, ser_valid, ser_bit, ser_last, sel, busy
  );

  modport slave (
    output load_valid, load_data, ser_ready,
    input  load_ready, ser_valid, ser_bit, ser_last, sel, busy
  );
endinterface

// File: rtl/mux_scan_serializer_select.sv
// N-to-1 combinational selector feeding the serial bit from the captured word.
module scan_select_mux #(
  parameter int N     = 16,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     data_q,
  input  logic [SEL_W-1:0] sel,
  output logic             bit_o
);

  assign bit_o = data_q[sel];

endmodule

// File: rtl/mux_scan_serializer.sv
// Parallel-to-serial frame scanner driving a 16-to-1 selector stage.
// Optional trailing even-parity beat is enabled by defining MUX_SCAN_PARITY_EN.
//
// state  | meaning
// IDLE   | waiting for a word, load_ready high
// SHIFT  | emitting data bits, sel walks across the word
// PARITY | emitting the even-parity beat, sel parked on the final index
module mux_scan_serializer
  import mux_scan_pkg::*;
#(
  parameter int N         = SCAN_DEFAULT_N,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux_scan_serializer_if.master bus
);

  localparam int SEL_W = $clog2(N);
  localparam logic [SEL_W-1:0] FIRST_SEL = MSB_FIRST ? SEL_W'(N - 1) : '0;
  localparam logic [SEL_W-1:0] LAST_SEL  = MSB_FIRST ? '0 : SEL_W'(N - 1);

  scan_state_t      state_q, state_d;
  logic [N-1:0]     data_q, data_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             ready_q, ready_d;
  logic             mux_bit;

  scan_select_mux #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_select (
    .data_q (data_q),
    .sel    (sel_q),
    .bit_o  (mux_bit)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (bus.load_valid) begin
          data_d  = bus.load_data;
          sel_d   = FIRST_SEL;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.ser_ready) begin
          // sel never wraps; it stays on the final index until the next load
          if (sel_q == LAST_SEL) begin
`ifdef MUX_SCAN_PARITY_EN
            state_d = PARITY;
`else
            state_d = IDLE;
`endif
          end else if (MSB_FIRST) begin
            sel_d = sel_q - 1'b1;
          end else begin
            sel_d = sel_q + 1'b1;
          end
        end
      end
`ifdef MUX_SCAN_PARITY_EN
      PARITY: begin
        if (bus.ser_ready) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase

    valid_d = (state_d != IDLE);
    ready_d = (state_d == IDLE);
`ifdef MUX_SCAN_PARITY_EN
    last_d  = (state_d == PARITY);
`else
    last_d  = (state_d == SHIFT) && (sel_d == LAST_SEL);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      ready_q <= ready_d;
    end
  end

  assign bus.load_ready = ready_q;
  assign bus.ser_valid  = valid_q;
  assign bus.busy       = valid_q;
  assign bus.ser_last   = last_q;
  assign bus.sel        = sel_q;
`ifdef MUX_SCAN_PARITY_EN
  assign bus.ser_bit    = valid_q & ((state_q == PARITY) ? ^data_q : mux_bit);
`else
  assign bus.ser_bit    = valid_q & mux_bit;
`endif

endmodule

// File: doc/mux_scan_serializer.md
# mux_scan_serializer

Parallel-to-serial frame scanner that sits directly upstream of the 16-to-1 selector stage and drives it. It accepts an N-bit word through a valid/ready handshake and registers it. A select counter then steps a 16-to-1 selector across the word, emitting one bit per accepted beat on a valid/ready serial port. It is the sequential front end that supplies both the data and the select lines consumed by the multiplexer stage.

## Interface
- `N`, default 16: word width. Must be a power of two, at least 2.
- `MSB_FIRST`, default 0:
  - 0: bit index 0 is sent first.
  - 1: bit index N-1 is sent first.
- `clk` input, 1 bit: single clock. All state updates on the rising edge.
- `rst_n` input, 1 bit: reset, synchronous, active-low.
- `load_valid` input, 1 bit: upstream word offered.
- `load_ready` output, 1 bit: block can accept a word.
- `load_data` input, N bits: word to serialize.
- `ser_valid` output, 1 bit: `ser_bit` is valid.
- `ser_ready` input, 1 bit: downstream accepts the current bit.
- `ser_bit` output, 1 bit: current serial bit.
- `ser_last` output, 1 bit: current bit is the final beat of the frame.
- `sel` output, $clog2(N) bits: current select index.
- `busy` output, 1 bit: frame in progress.

## Operation
- **States:** IDLE, SHIFT, and PARITY (PARITY only when the macro is defined).
- **IDLE:**
  - `load_ready`=1, `busy`=0, `ser_valid`=0.
  - On `load_valid`&&`load_ready`: capture `load_data` into `data_q`; load `sel` with 0 (or N-1 when MSB_FIRST); go to SHIFT.
- **SHIFT:**
  - `ser_valid`=1, `busy`=1, `load_ready`=0.
  - `ser_bit` = `data_q[sel]`, selected combinationally from registered operands.
  - On `ser_valid`&&`ser_ready`, `sel` steps by +1 (or -1 when MSB_FIRST).
  - On the final index, the handshake moves the block to IDLE (or PARITY). `sel` does not wrap; it is reloaded on the next load.
- **Stall:** while `ser_ready`=0, `sel`, `data_q`, `ser_bit` and `ser_last` hold stable.
- **`ser_last`:** 1 only on the final beat of the frame, while `ser_valid`=1.
- **Outputs when not valid:** `ser_bit` is forced to 0 whenever `ser_valid`=0.
- **Inputs during a frame:** `load_valid` and `load_data` are ignored while busy. No word is lost, because `load_ready`=0.
- **Reset mid-frame:** the frame is abandoned with no further beats; the block returns to IDLE on the next edge.

## Timing
- **Reset values:** state IDLE, `load_ready`=1, `ser_valid`=0, `ser_bit`=0, `ser_last`=0, `sel`=0, `busy`=0, `data_q`=0.
- **Latency:** the first bit is valid in the cycle after the load handshake.
- **Throughput:** with `ser_ready` held at 1, a frame takes N beats (N+1 with parity) plus one IDLE cycle before the next load. Back-to-back frames are separated by exactly one bubble.
- **Output timing:** all outputs derive from registers only. There is no combinational path from `ser_ready` or `load_valid` to any output.

## Configuration
- **Macro:** `MUX_SCAN_PARITY_EN`.
- **Defined:**
  - After the last data bit, the PARITY state emits one extra beat carrying the even parity of `data_q` (XOR of all bits).
  - `ser_last` moves to that parity beat.
  - `sel` holds at the final data index during the parity beat.
  - Frame length is N+1.
- **Undefined:** no PARITY state; frame length is N; `ser_last` is on the final data bit.

## Structure
- **Shared package `mux_scan_pkg`:**
  - typedef enum `scan_state_t` {IDLE, SHIFT, PARITY}.
  - localparam `SCAN_DEFAULT_N` = 16.
- **Sub-module `scan_select_mux`:** parameterized N-to-1 combinational selector taking `data_q` and `sel`, producing the raw bit. It keeps the selector separable from the sequencing logic.

## Test plan
- **LSB-first serialization:**
  - Stimulus: N=16, MSB_FIRST=0, load 16'hA5C3, `ser_ready`=1.
  - Required: bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 on consecutive cycles starting the cycle after the load.
  - Required: `ser_last` on beat 16 only; `load_ready` returns to 1 on the following cycle.
- **MSB-first ordering:**
  - Stimulus: MSB_FIRST=1, load 16'h8001.
  - Required: 1, then fourteen 0s, then 1; `sel` counts 15 down to 0.
- **Backpressure:**
  - Stimulus: drop `ser_ready` for 3 cycles at beat 5 of 16'hA5C3.
  - Required: `ser_bit`, `sel`=4 and `ser_valid`=1 held stable; the sequence resumes without loss or duplication.
- **Reset mid-frame:**
  - Stimulus: assert `rst_n`=0 at beat 7.
  - Required: at the next edge, all outputs equal their reset values and `load_ready`=1; a new load of 16'h00FF serializes correctly.
- **Load while busy:**
  - Stimulus: hold `load_valid`=1 with changing `load_data` during a frame.
  - Required: the current frame is unaffected; the next word is accepted only in IDLE, after exactly one bubble.
- **Parity (with `MUX_SCAN_PARITY_EN`):**
  - Stimulus: load 16'h0001.
  - Required: 17 beats, parity bit = 1, `ser_last` on beat 17.
  - Stimulus: load 16'hA5C3.
  - Required: parity bit = 0.
